// File: rtl/uart_word_controller.sv
// uart_word_controller: packs received UART bytes into little-endian core words and
// splits core words into bytes for transmission, with full-depth byte FIFOs on both sides.
`timescale 1ns/1ps
`default_nettype none

module uart_word_controller #(
  parameter int BUFFER_BIT_WIDTH = 10,
  parameter int WORD_BYTES       = 4,
  parameter int LOST_COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic                          phy_reset,
  input  logic [7:0]                    recv_data,
  input  logic                          recv_ok,
  output logic [7:0]                    trans_data,
  output logic                          trans_ok,
  input  logic                          trans_busy,
  input  logic [8*WORD_BYTES-1:0]       in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [8*WORD_BYTES-1:0]       out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  input  logic                          flush_rx,
  input  logic                          flush_tx,
  input  logic                          clear_lost,
  output logic                          lost,
  output logic [LOST_COUNT_WIDTH-1:0]   lost_count,
  output logic [BUFFER_BIT_WIDTH:0]     rx_length,
  output logic [BUFFER_BIT_WIDTH:0]     tx_length
);

  localparam int                        DEPTH     = 2 ** BUFFER_BIT_WIDTH;
  localparam int                        PW        = BUFFER_BIT_WIDTH + 1;
  localparam int                        WW        = 8 * WORD_BYTES;
  localparam logic [1:0]                LAST_LANE = 2'(WORD_BYTES - 1);
  localparam logic [PW-1:0]             FULL_LEN  = PW'(DEPTH);
  localparam logic [PW-1:0]             PTR_ONE   = PW'(1);
  localparam logic [LOST_COUNT_WIDTH-1:0] CNT_ONE = LOST_COUNT_WIDTH'(1);

  typedef enum logic {RX_GATHER = 1'b0, RX_HOLD = 1'b1} rx_state_t;
  typedef enum logic {TX_IDLE = 1'b0, TX_PUSH = 1'b1} tx_state_t;

  logic [7:0]                  rx_mem_q [DEPTH];
  logic [7:0]                  tx_mem_q [DEPTH];

  logic [PW-1:0]               rx_head_q, rx_head_d, rx_tail_q, rx_tail_d;
  logic [PW-1:0]               tx_head_q, tx_head_d, tx_tail_q, tx_tail_d;
  rx_state_t                   rx_state_q, rx_state_d;
  tx_state_t                   tx_state_q, tx_state_d;
  logic [1:0]                  rx_lane_q, rx_lane_d, tx_lane_q, tx_lane_d;
  logic [WW-1:0]               rx_word_q, rx_word_d, tx_word_q, tx_word_d;
  logic                        out_valid_q, out_valid_d;
  logic                        in_ready_q, in_ready_d;
  logic                        trans_ok_q, trans_ok_d;
  logic [7:0]                  trans_data_q, trans_data_d;
  logic                        lost_q, lost_d;
  logic [LOST_COUNT_WIDTH-1:0] lost_count_q, lost_count_d;

  logic [PW-1:0] rx_len, tx_len;
  logic          rx_full, rx_empty, tx_full, tx_empty;
  logic          rx_wr_en, rx_drop, rx_pop;
  logic          tx_accept, tx_push, tx_pop;
  logic [7:0]    rx_byte, tx_byte;

  assign rx_len   = rx_tail_q - rx_head_q;
  assign tx_len   = tx_tail_q - tx_head_q;
  assign rx_full  = (rx_len == FULL_LEN);
  assign rx_empty = (rx_len == '0);
  assign tx_full  = (tx_len == FULL_LEN);
  assign tx_empty = (tx_len == '0);
  assign rx_byte  = rx_mem_q[rx_head_q[BUFFER_BIT_WIDTH-1:0]];

  // A byte arriving with flush_rx is discarded outright, so it is neither stored nor counted lost.
  assign rx_wr_en  = recv_ok && !rx_full && !flush_rx;
  assign rx_drop   = recv_ok && rx_full && !flush_rx;
  assign rx_pop    = (rx_state_q == RX_GATHER) && !rx_empty && !flush_rx;
  assign tx_accept = (tx_state_q == TX_IDLE) && in_valid && in_ready_q && !flush_tx;
  assign tx_push   = (tx_state_q == TX_PUSH) && !tx_full && !flush_tx;
  assign tx_pop    = !trans_busy && !tx_empty && !trans_ok_q && !flush_tx;

  always_comb begin
    tx_byte = tx_word_q[7:0];
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (tx_lane_q == 2'(i)) tx_byte = tx_word_q[i*8 +: 8];
    end
  end

  always_comb begin
    rx_head_d    = rx_head_q;
    rx_tail_d    = rx_tail_q;
    rx_state_d   = rx_state_q;
    rx_lane_d    = rx_lane_q;
    rx_word_d    = rx_word_q;
    out_valid_d  = out_valid_q;
    lost_d       = lost_q;
    lost_count_d = lost_count_q;

    if (rx_wr_en) rx_tail_d = rx_tail_q + PTR_ONE;
    if (rx_pop) begin
      rx_head_d = rx_head_q + PTR_ONE;
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (rx_lane_q == 2'(i)) rx_word_d[i*8 +: 8] = rx_byte;
      end
      if (rx_lane_q == LAST_LANE) begin
        rx_state_d  = RX_HOLD;
        rx_lane_d   = 2'd0;
        out_valid_d = 1'b1;
      end else begin
        rx_lane_d = rx_lane_q + 2'd1;
      end
    end
    if (rx_state_q == RX_HOLD && out_ready) begin
      rx_state_d  = RX_GATHER;
      rx_lane_d   = 2'd0;
      out_valid_d = 1'b0;
    end
    if (flush_rx) begin
      rx_head_d   = '0;
      rx_tail_d   = '0;
      rx_state_d  = RX_GATHER;
      rx_lane_d   = 2'd0;
      out_valid_d = 1'b0;
    end

    if (clear_lost) begin
      lost_d       = 1'b0;
      lost_count_d = '0;
    end
    if (rx_drop) begin
      lost_d = 1'b1;
      if (clear_lost) lost_count_d = CNT_ONE;
      else if (lost_count_q != '1) lost_count_d = lost_count_q + CNT_ONE;
    end
  end

  always_comb begin
    tx_head_d    = tx_head_q;
    tx_tail_d    = tx_tail_q;
    tx_state_d   = tx_state_q;
    tx_lane_d    = tx_lane_q;
    tx_word_d    = tx_word_q;
    in_ready_d   = in_ready_q;
    trans_ok_d   = tx_pop;
    trans_data_d = tx_pop ? tx_mem_q[tx_head_q[BUFFER_BIT_WIDTH-1:0]] : trans_data_q;

    if (tx_pop) tx_head_d = tx_head_q + PTR_ONE;
    if (tx_accept) begin
      tx_word_d  = in_data;
      tx_state_d = TX_PUSH;
      tx_lane_d  = 2'd0;
      in_ready_d = 1'b0;
    end
    if (tx_push) begin
      tx_tail_d = tx_tail_q + PTR_ONE;
      if (tx_lane_q == LAST_LANE) begin
        tx_state_d = TX_IDLE;
        tx_lane_d  = 2'd0;
        in_ready_d = 1'b1;
      end else begin
        tx_lane_d = tx_lane_q + 2'd1;
      end
    end
    if (flush_tx) begin
      tx_head_d  = '0;
      tx_tail_d  = '0;
      tx_state_d = TX_IDLE;
      tx_lane_d  = 2'd0;
      in_ready_d = 1'b1;
    end
  end

  // Storage carries no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (rx_wr_en) rx_mem_q[rx_tail_q[BUFFER_BIT_WIDTH-1:0]] <= recv_data;
    if (tx_push)  tx_mem_q[tx_tail_q[BUFFER_BIT_WIDTH-1:0]] <= tx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_head_q    <= '0;
      rx_tail_q    <= '0;
      tx_head_q    <= '0;
      tx_tail_q    <= '0;
      rx_state_q   <= RX_GATHER;
      tx_state_q   <= TX_IDLE;
      rx_lane_q    <= 2'd0;
      tx_lane_q    <= 2'd0;
      rx_word_q    <= '0;
      tx_word_q    <= '0;
      out_valid_q  <= 1'b0;
      in_ready_q   <= 1'b1;
      trans_ok_q   <= 1'b0;
      trans_data_q <= 8'h00;
      lost_q       <= 1'b0;
      lost_count_q <= '0;
    end else begin
      rx_head_q    <= rx_head_d;
      rx_tail_q    <= rx_tail_d;
      tx_head_q    <= tx_head_d;
      tx_tail_q    <= tx_tail_d;
      rx_state_q   <= rx_state_d;
      tx_state_q   <= tx_state_d;
      rx_lane_q    <= rx_lane_d;
      tx_lane_q    <= tx_lane_d;
      rx_word_q    <= rx_word_d;
      tx_word_q    <= tx_word_d;
      out_valid_q  <= out_valid_d;
      in_ready_q   <= in_ready_d;
      trans_ok_q   <= trans_ok_d;
      trans_data_q <= trans_data_d;
      lost_q       <= lost_d;
      lost_count_q <= lost_count_d;
    end
  end

  assign phy_reset  = reset;
  assign trans_data = trans_data_q;
  assign trans_ok   = trans_ok_q;
  assign in_ready   = in_ready_q;
  assign out_data   = rx_word_q;
  assign out_valid  = out_valid_q;
  assign lost       = lost_q;
  assign lost_count = lost_count_q;
  assign rx_length  = rx_len;
  assign tx_length  = tx_len;

endmodule

`default_nettype wire

// File: tb/tb_uart_word_controller.sv
// Directed bench for uart_word_controller: 4-entry FIFOs, 4-byte words, 2-bit lost counter.
`timescale 1ns/1ps
`default_nettype none

module tb_uart_word_controller;

  localparam int BBW = 2;
  localparam int WB  = 4;
  localparam int LCW = 2;

  logic            clk = 1'b0;
  logic            reset, phy_reset;
  logic [7:0]      recv_data, trans_data;
  logic            recv_ok, trans_ok, trans_busy;
  logic [8*WB-1:0] in_data, out_data;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic            flush_rx, flush_tx, clear_lost, lost;
  logic [LCW-1:0]  lost_count;
  logic [BBW:0]    rx_length, tx_length;

  int n_checks = 0;
  int n_fail   = 0;

  // Transmitter model: busy rises one cycle after trans_ok and stays up for 10 cycles.
  logic [7:0] tx_seen[$];
  int         busy_cnt  = 0;
  int         gap_err   = 0;
  logic       hold_busy = 1'b0;
  logic       prev_ok   = 1'b0;
  int         sz_before;

  assign trans_busy = hold_busy || (busy_cnt != 0);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (trans_ok) begin
      tx_seen.push_back(trans_data);
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (trans_ok && prev_ok) gap_err++;
    prev_ok <= trans_ok;
  end

  uart_word_controller #(
    .BUFFER_BIT_WIDTH (BBW),
    .WORD_BYTES       (WB),
    .LOST_COUNT_WIDTH (LCW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .phy_reset  (phy_reset),
    .recv_data  (recv_data),
    .recv_ok    (recv_ok),
    .trans_data (trans_data),
    .trans_ok   (trans_ok),
    .trans_busy (trans_busy),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flush_rx   (flush_rx),
    .flush_tx   (flush_tx),
    .clear_lost (clear_lost),
    .lost       (lost),
    .lost_count (lost_count),
    .rx_length  (rx_length),
    .tx_length  (tx_length)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    recv_data = b;
    recv_ok   = 1'b1;
    tick();
    recv_ok   = 1'b0;
  endtask

  task automatic wait_out_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic wait_tx(input string tag, input int n, input int bound);
    int k = 0;
    while (tx_seen.size() < n && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(tx_seen.size()), 32'(n));
  endtask

  initial begin
    reset = 1'b1; recv_data = 8'h00; recv_ok = 1'b0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b0; flush_rx = 1'b0; flush_tx = 1'b0; clear_lost = 1'b0;

    tick(2);
    check("phy_reset_high", 32'(phy_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("phy_reset_low", 32'(phy_reset), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_trans_ok", 32'(trans_ok), 32'd0);
    check("rst_lost", 32'(lost), 32'd0);
    check("rst_lost_count", 32'(lost_count), 32'd0);
    check("rst_rx_length", 32'(rx_length), 32'd0);
    check("rst_tx_length", 32'(tx_length), 32'd0);

    // RX packing, little-endian
    out_ready = 1'b1;
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_out_valid("pack_valid");
    check("pack_data", out_data, 32'h44332211);
    tick();
    check("pack_single_beat", 32'(out_valid), 32'd0);
    check("pack_rx_empty", 32'(rx_length), 32'd0);

    // TX split with paced transmitter
    tx_seen.delete();
    in_data = 32'hA1B2C3D4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("split_ready_low0", 32'(in_ready), 32'd0);
    tick(3);
    check("split_ready_low3", 32'(in_ready), 32'd0);
    tick();
    check("split_ready_back", 32'(in_ready), 32'd1);
    wait_tx("split_count", 4, 200);
    if (tx_seen.size() == 4) begin
      check("split_b0", 32'(tx_seen[0]), 32'hD4);
      check("split_b1", 32'(tx_seen[1]), 32'hC3);
      check("split_b2", 32'(tx_seen[2]), 32'hB2);
      check("split_b3", 32'(tx_seen[3]), 32'hA1);
    end
    check("split_tx_empty", 32'(tx_length), 32'd0);

    // RX overflow: 4 bytes held as a word, 4 fill the FIFO, 3 dropped
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("ovf_full_len", 32'(rx_length), 32'd4);
    check("ovf_no_loss_yet", 32'(lost), 32'd0);
    for (int i = 9; i <= 11; i++) send_byte(8'(i));
    check("ovf_len_held", 32'(rx_length), 32'd4);
    check("ovf_hold_valid", 32'(out_valid), 32'd1);
    check("ovf_hold_data", out_data, 32'h04030201);
    check("ovf_lost", 32'(lost), 32'd1);
    check("ovf_lost_count", 32'(lost_count), 32'd3);
    clear_lost = 1'b1; tick(); clear_lost = 1'b0;
    check("clr_lost", 32'(lost), 32'd0);
    check("clr_count", 32'(lost_count), 32'd0);
    out_ready = 1'b1;
    tick();
    wait_out_valid("ovf_second_valid");
    check("ovf_second_data", out_data, 32'h08070605);
    tick();
    check("ovf_drained", 32'(rx_length), 32'd0);
    check("ovf_valid_drop", 32'(out_valid), 32'd0);

    // Saturation, clear_lost racing a drop, flush while full
    out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_byte(8'h20 + 8'(i));
    check("sat_count", 32'(lost_count), 32'd3);
    check("sat_lost", 32'(lost), 32'd1);
    clear_lost = 1'b1;
    send_byte(8'hE0);
    clear_lost = 1'b0;
    check("clr_drop_lost", 32'(lost), 32'd1);
    check("clr_drop_count", 32'(lost_count), 32'd1);
    flush_rx = 1'b1;
    send_byte(8'hEE);
    flush_rx = 1'b0;
    check("flush_full_len", 32'(rx_length), 32'd0);
    check("flush_full_valid", 32'(out_valid), 32'd0);
    check("flush_keeps_count", 32'(lost_count), 32'd1);
    check("flush_keeps_lost", 32'(lost), 32'd1);
    clear_lost = 1'b1; tick(); clear_lost = 1'b0;

    // Partial word discarded by flush_rx with a coincident byte
    out_ready = 1'b1;
    send_byte(8'hAA); send_byte(8'hBB);
    flush_rx = 1'b1;
    send_byte(8'hCC);
    flush_rx = 1'b0;
    check("pflush_len", 32'(rx_length), 32'd0);
    check("pflush_count", 32'(lost_count), 32'd0);
    tick(6);
    check("pflush_no_word", 32'(out_valid), 32'd0);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    wait_out_valid("pflush_valid");
    check("pflush_data", out_data, 32'h88776655);

    // TX backpressure: busy held, second word stalls in push
    tx_seen.delete();
    hold_busy = 1'b1;
    in_data = 32'h44332211; in_valid = 1'b1;
    tick();
    in_data = 32'h88776655;
    for (int k = 0; k < 20 && !in_ready; k++) tick();
    check("bp_ready_after_w1", 32'(in_ready), 32'd1);
    check("bp_fifo_full", 32'(tx_length), 32'd4);
    tick();
    in_valid = 1'b0;
    check("bp_w2_taken", 32'(in_ready), 32'd0);
    tick(5);
    check("bp_stalled_ready", 32'(in_ready), 32'd0);
    check("bp_stalled_len", 32'(tx_length), 32'd4);
    check("bp_nothing_sent", 32'(tx_seen.size()), 32'd0);
    hold_busy = 1'b0;
    wait_tx("bp_count", 8, 400);
    if (tx_seen.size() == 8) begin
      for (int i = 0; i < 8; i++) check("bp_byte", 32'(tx_seen[i]), 32'h11 * (i + 1));
    end
    check("bp_gap", 32'(gap_err), 32'd0);
    tick(2);
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_tx_empty", 32'(tx_length), 32'd0);

    // flush_tx with a full FIFO while a new word is offered
    tx_seen.delete();
    hold_busy = 1'b1;
    in_data = 32'hDEADBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(4);
    check("tflush_pre_len", 32'(tx_length), 32'd4);
    flush_tx = 1'b1; in_data = 32'hCAFEF00D; in_valid = 1'b1;
    tick();
    flush_tx = 1'b0; in_valid = 1'b0;
    check("tflush_len", 32'(tx_length), 32'd0);
    check("tflush_ready", 32'(in_ready), 32'd1);
    tick(2);
    check("tflush_no_accept", 32'(tx_length), 32'd0);
    hold_busy = 1'b0;
    tick(30);
    check("tflush_nothing_sent", 32'(tx_seen.size()), 32'd0);

    // Reset mid-operation
    out_ready = 1'b0;
    in_data = 32'h01020304; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    send_byte(8'h99);
    sz_before = tx_seen.size();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mrst_rx_len", 32'(rx_length), 32'd0);
    check("mrst_tx_len", 32'(tx_length), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    check("mrst_trans_ok", 32'(trans_ok), 32'd0);
    tick(30);
    check("mrst_no_word", 32'(out_valid), 32'd0);
    check("mrst_no_tx", 32'(tx_seen.size()), 32'(sz_before));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
